// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: source indices,
// default stall/flush masks, FSM state encoding and a saturating-counter helper.
package pipeline_hazard_ctrl_pkg;

    localparam int SRC_FETCH_IDLE = 0;
    localparam int SRC_LOAD_USE   = 1;
    localparam int SRC_MUL_DIV    = 2;
    localparam int SRC_JUMP       = 3;
    localparam int SRC_TRAP_STALL = 4;
    localparam int SRC_TRAP_FLUSH = 5;
    localparam int SRC_IF_RAM     = 6;
    localparam int SRC_MEM_RAM    = 7;

    localparam int DEF_NUM_STAGES = 6;
    localparam int DEF_NUM_REQ    = 8;

    // Slice i sits at bits [i*6 +: 6]; the highest source is leftmost.
    localparam logic [47:0] DEF_STALL_MASKS = {
        6'b001111,  // mem_ram
        6'b001111,  // if_ram
        6'b000010,  // trap_flush
        6'b111111,  // trap_stall
        6'b000010,  // jump
        6'b000111,  // mul_div
        6'b000011,  // load_use
        6'b000111   // fetch_idle
    };

    localparam logic [47:0] DEF_FLUSH_MASKS = {
        6'b100000,  // mem_ram
        6'b000000,  // if_ram
        6'b001110,  // trap_flush
        6'b001110,  // trap_stall
        6'b001110,  // jump
        6'b010000,  // mul_div
        6'b001000,  // load_use
        6'b001000   // fetch_idle
    };

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HANG = 2'b10
    } hz_state_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != CNT_MAX)) ? (value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/hazard_prio_enc.sv
// Priority encoder: reports whether any request is set and the highest set index.
module hazard_prio_enc
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int N   = DEF_NUM_REQ,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    output logic           valid_o,
    output logic [IDW-1:0] id_o
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        for (int i = 0; i < N; i++) begin
            id_o = req_i[i] ? IDW'(i) : id_o;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates hazard sources into per-stage stall and
// flush controls, with a post-reset flush phase, a stall watchdog and activity counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int                            NUM_STAGES  = DEF_NUM_STAGES,
    parameter int                            NUM_REQ     = DEF_NUM_REQ,
    parameter logic [NUM_REQ*NUM_STAGES-1:0] STALL_MASKS = DEF_STALL_MASKS,
    parameter logic [NUM_REQ*NUM_STAGES-1:0] FLUSH_MASKS = DEF_FLUSH_MASKS,
    parameter int                            INIT_CYCLES = 4,
    parameter int                            TIMEOUT     = 1024,
    parameter bit                            FLUSH_PULSE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       clr_cnt_i,
    output logic [NUM_STAGES-1:0]      stall_o,
    output logic [NUM_STAGES-1:0]      flush_o,
    output logic                       win_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] win_id_o,
    output logic                       hang_o,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                flush_cnt_o
);

    localparam int                ID_W      = $clog2(NUM_REQ);
    localparam int                INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
    localparam logic [31:0]       WD_LAST   = 32'(TIMEOUT - 1);

    hz_state_e           state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [31:0]         wd_q, wd_d;
    logic                prev_valid_q, prev_valid_d;
    logic [ID_W-1:0]     prev_id_q, prev_id_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic [31:0]         flush_cnt_q, flush_cnt_d;

    logic                req_valid_s;
    logic [ID_W-1:0]     req_id_s;
    logic [NUM_STAGES-1:0] stall_mask_s, flush_mask_s;
    logic [NUM_STAGES-1:0] stall_s, flush_s;
    logic                win_valid_s;
    logic [ID_W-1:0]     win_id_s;
    logic                fresh_s;

    hazard_prio_enc #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_prio_enc (
        .req_i   (req_i),
        .valid_o (req_valid_s),
        .id_o    (req_id_s)
    );

    // Zero-latency stall/flush selection from the current winner.
    always_comb begin
        stall_mask_s = STALL_MASKS[req_id_s*NUM_STAGES +: NUM_STAGES];
        flush_mask_s = FLUSH_MASKS[req_id_s*NUM_STAGES +: NUM_STAGES];
        fresh_s      = !prev_valid_q || (prev_id_q != req_id_s);
        stall_s      = '0;
        flush_s      = '0;
        win_valid_s  = 1'b0;
        win_id_s     = '0;
        if (state_q == ST_INIT) begin
            flush_s = '1;
        end else if (req_valid_s) begin
            win_valid_s = 1'b1;
            win_id_s    = req_id_s;
            stall_s     = stall_mask_s;
            // A new winner episode (or a change of winner) fires its flush once.
            if (!FLUSH_PULSE || fresh_s) begin
                flush_s = flush_mask_s;
            end else begin
                flush_s = '0;
            end
        end else begin
            stall_s = '0;
            flush_s = '0;
        end
    end

    assign stall_o     = stall_s;
    assign flush_o     = flush_s;
    assign win_valid_o = win_valid_s;
    assign win_id_o    = win_id_s;
    assign hang_o      = (state_q == ST_HANG);
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // Next-state logic for the FSM, watchdog, previous-winner tracking and counters.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wd_d         = wd_q;
        prev_valid_d = prev_valid_q;
        prev_id_d    = prev_id_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        case (state_q)
            ST_INIT: begin
                prev_valid_d = 1'b0;
                prev_id_d    = '0;
                if (init_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - INIT_W'(1);
                end
            end
            ST_RUN, ST_HANG: begin
                prev_valid_d = win_valid_s;
                prev_id_d    = win_id_s;
                if (clr_cnt_i) begin
                    state_d     = ST_RUN;
                    wd_d        = 32'd0;
                    stall_cnt_d = 32'd0;
                    flush_cnt_d = 32'd0;
                end else begin
                    stall_cnt_d = sat_inc(stall_cnt_q, |stall_s);
                    flush_cnt_d = sat_inc(flush_cnt_q, |flush_s);
                    if (stall_s == '0) begin
                        wd_d = 32'd0;
                    end else if (state_q == ST_RUN) begin
                        wd_d = wd_q + 32'd1;
                        if (wd_q == WD_LAST) begin
                            state_d = ST_HANG;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        // Already hung: only clr_cnt_i leaves HANG, so hold.
                        wd_d = wd_q;
                    end
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = INIT_LOAD;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= INIT_LOAD;
            wd_q         <= 32'd0;
            prev_valid_q <= 1'b0;
            prev_id_q    <= '0;
            stall_cnt_q  <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            wd_q         <= wd_d;
            prev_valid_q <= prev_valid_d;
            prev_id_q    <= prev_id_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two builds (pulsed and level flush,
// TIMEOUT 8) share stimulus; a reference model predicts each cycle's outputs.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 8;

    typedef struct {
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic        wv;
        logic [2:0]  wid;
        logic        hang;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic       clr_cnt_i;

    logic [5:0]  stall_w [2];
    logic [5:0]  flush_w [2];
    logic        wv_w    [2];
    logic [2:0]  wid_w   [2];
    logic        hang_w  [2];
    logic [31:0] sc_w    [2];
    logic [31:0] fc_w    [2];

    // Reference tables written from the source/mask table.
    logic [5:0] stall_tbl [8] = '{6'b000111, 6'b000011, 6'b000111, 6'b000010,
                                  6'b111111, 6'b000010, 6'b001111, 6'b001111};
    logic [5:0] flush_tbl [8] = '{6'b001000, 6'b001000, 6'b010000, 6'b001110,
                                  6'b001110, 6'b001110, 6'b000000, 6'b100000};

    int     init_left [2];
    int     wd_m      [2];
    int     prev_w    [2];
    bit     hang_m    [2];
    longint sc_m      [2];
    longint fc_m      [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TMO), .FLUSH_PULSE(1'b1)) u_dut_pulse (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .clr_cnt_i   (clr_cnt_i),
        .stall_o     (stall_w[0]),
        .flush_o     (flush_w[0]),
        .win_valid_o (wv_w[0]),
        .win_id_o    (wid_w[0]),
        .hang_o      (hang_w[0]),
        .stall_cnt_o (sc_w[0]),
        .flush_cnt_o (fc_w[0])
    );

    pipeline_hazard_ctrl #(.TIMEOUT(TMO), .FLUSH_PULSE(1'b0)) u_dut_level (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .clr_cnt_i   (clr_cnt_i),
        .stall_o     (stall_w[1]),
        .flush_o     (flush_w[1]),
        .win_valid_o (wv_w[1]),
        .win_id_o    (wid_w[1]),
        .hang_o      (hang_w[1]),
        .stall_cnt_o (sc_w[1]),
        .flush_cnt_o (fc_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset(input int k);
        init_left[k] = 4;
        wd_m[k]      = 0;
        prev_w[k]    = -1;
        hang_m[k]    = 1'b0;
        sc_m[k]      = 0;
        fc_m[k]      = 0;
    endfunction

    function automatic exp_t predict(input int k, input logic [7:0] r);
        exp_t e;
        int   w = -1;
        e.sc   = sc_m[k][31:0];
        e.fc   = fc_m[k][31:0];
        e.hang = hang_m[k];
        e.wv   = 1'b0;
        e.wid  = 3'd0;
        e.stall = 6'd0;
        e.flush = 6'd0;
        if (init_left[k] > 0) begin
            e.flush = 6'h3F;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (w < 0 && r[i]) w = i;
            end
            if (w >= 0) begin
                e.wv    = 1'b1;
                e.wid   = 3'(w);
                e.stall = stall_tbl[w];
                // Level build (k==1) flushes every winning cycle; pulsed build once per episode.
                if (k == 1 || prev_w[k] != w) e.flush = flush_tbl[w];
            end
        end
        return e;
    endfunction

    function automatic void advance(input int k, input logic [7:0] r, input logic c);
        exp_t e = predict(k, r);
        if (init_left[k] > 0) begin
            init_left[k]--;
        end else begin
            prev_w[k] = e.wv ? int'(e.wid) : -1;
            if (c) begin
                sc_m[k] = 0; fc_m[k] = 0; wd_m[k] = 0; hang_m[k] = 1'b0;
            end else begin
                if (e.stall != 6'd0 && sc_m[k] < 64'hFFFF_FFFF) sc_m[k]++;
                if (e.flush != 6'd0 && fc_m[k] < 64'hFFFF_FFFF) fc_m[k]++;
                if (e.stall != 6'd0) begin
                    wd_m[k]++;
                    if (wd_m[k] >= TMO) hang_m[k] = 1'b1;
                end else begin
                    wd_m[k] = 0;
                end
            end
        end
    endfunction

    task automatic cycle(input logic [7:0] r, input logic c, input logic rn);
        @(negedge clk);
        #1;
        req_i     = r;
        clr_cnt_i = c;
        rst_n     = rn;
        for (int k = 0; k < 2; k++) begin
            if (!rn) model_reset(k);
        end
        q0.push_back(predict(0, r));
        q1.push_back(predict(1, r));
        @(posedge clk);
        if (rn) begin
            for (int k = 0; k < 2; k++) advance(k, r, c);
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just before the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("stall_o",     k, 32'(stall_w[k]), 32'(e.stall));
                    chk("flush_o",     k, 32'(flush_w[k]), 32'(e.flush));
                    chk("win_valid_o", k, 32'(wv_w[k]),    32'(e.wv));
                    chk("win_id_o",    k, 32'(wid_w[k]),   32'(e.wid));
                    chk("hang_o",      k, 32'(hang_w[k]),  32'(e.hang));
                    chk("stall_cnt_o", k, sc_w[k],         e.sc);
                    chk("flush_cnt_o", k, fc_w[k],         e.fc);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic       c;
        logic       rn;
        rst_n     = 1'b0;
        req_i     = 8'h00;
        clr_cnt_i = 1'b0;
        for (int k = 0; k < 2; k++) model_reset(k);

        repeat (2) cycle(8'h00, 1'b0, 1'b0);
        // Post-reset flush phase, then idle.
        repeat (6) cycle(8'h00, 1'b0, 1'b1);
        // jump + load_use held: one flush pulse, steady stall.
        repeat (3) cycle(8'h0A, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        // Winner change jump -> mem_ram fires the new flush immediately.
        repeat (2) cycle(8'h08, 1'b0, 1'b1);
        repeat (2) cycle(8'h80, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        // Watchdog: 8 stall cycles reach HANG; sticky until clear.
        repeat (8) cycle(8'h40, 1'b0, 1'b1);
        repeat (2) cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        repeat (2) cycle(8'h00, 1'b0, 1'b1);
        repeat (3) cycle(8'h04, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        // Reset asserted in the middle of a stall.
        repeat (3) cycle(8'h10, 1'b0, 1'b1);
        repeat (2) cycle(8'h10, 1'b0, 1'b0);
        repeat (3) cycle(8'h10, 1'b0, 1'b1);

        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r = 8'h00;
                    1:       r = 8'd1 << $urandom_range(0, 7);
                    2:       r = 8'($urandom);
                    default: r = (8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7));
                endcase
            end
            c  = ($urandom_range(0, 39) == 0);
            rn = ($urandom_range(0, 199) != 0);
            cycle(r, c, rn);
        end
        cycle(8'h00, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("queue_drain", 0, 32'(q0.size()), 32'd0);
        chk("queue_drain", 1, 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
